// File: rtl/mixcolumns_engine_pkg.sv
// Shared AES definitions: widths, MixColumns mode encodings, FSM states and
// the GF(2^8) constant-multiplier helpers used by the column transform.
package mixcolumns_engine_pkg;

    localparam int TEXT_WIDTH = 128;
    localparam int BYTE_WIDTH = 8;
    localparam int COL_WIDTH  = 32;

    localparam logic [1:0] MC_FWD = 2'b00;
    localparam logic [1:0] MC_INV = 2'b01;
    localparam logic [1:0] MC_BYP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mc_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; with a constant c this folds to an xtime chain.
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] c);
        logic [7:0] acc;
        logic [7:0] pw;
        acc = 8'h00;
        pw  = x;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (c[i] ? pw : 8'h00);
            pw  = xtime(pw);
        end
        return acc;
    endfunction

    // 2'b11 is folded into bypass.
    function automatic logic mc_is_bypass(input logic [1:0] mode);
        return (mode == MC_BYP) || (mode == 2'b11);
    endfunction

    function automatic logic [COL_WIDTH-1:0] get_col(input logic [TEXT_WIDTH-1:0] s,
                                                     input logic [1:0] idx);
        case (idx)
            2'd0:    get_col = s[127:96];
            2'd1:    get_col = s[95:64];
            2'd2:    get_col = s[63:32];
            default: get_col = s[31:0];
        endcase
    endfunction

    function automatic logic [TEXT_WIDTH-1:0] put_col(input logic [TEXT_WIDTH-1:0] s,
                                                      input logic [1:0] idx,
                                                      input logic [COL_WIDTH-1:0] col);
        logic [TEXT_WIDTH-1:0] r;
        r = s;
        case (idx)
            2'd0:    r[127:96] = col;
            2'd1:    r[95:64]  = col;
            2'd2:    r[63:32]  = col;
            default: r[31:0]   = col;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mixcolumns_engine_if.sv
// Valid/ready bus of the MixColumns engine: input state port, result port, busy flag.
interface mixcolumns_engine_if;
    import mixcolumns_engine_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_mode;
    logic [TEXT_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [TEXT_WIDTH-1:0] out_data;
    logic                  busy;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/mixcolumns_engine_mix.sv
// Combinational (Inv)MixColumns of one 32-bit column; row r of the column is byte r.
module mix_single_column
    import mixcolumns_engine_pkg::*;
(
    input  logic [COL_WIDTH-1:0] col_i,
    input  logic                 inv_i,
    output logic [COL_WIDTH-1:0] col_o
);

    logic [BYTE_WIDTH-1:0] a_s    [4];
    logic [BYTE_WIDTH-1:0] b_s    [4];
    logic [BYTE_WIDTH-1:0] coef_s [4];

    // Row r multiplies byte (r+j) by coef[j]: the circulant matrix rotated per row.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            a_s[r] = col_i[31 - 8*r -: 8];
        end
        if (inv_i) begin
            coef_s = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        end else begin
            coef_s = '{8'h02, 8'h03, 8'h01, 8'h01};
        end
        for (int r = 0; r < 4; r++) begin
            b_s[r] = 8'h00;
            for (int j = 0; j < 4; j++) begin
                b_s[r] = b_s[r] ^ gmul(a_s[(r + j) % 4], coef_s[j]);
            end
        end
        col_o = {b_s[0], b_s[1], b_s[2], b_s[3]};
    end

endmodule

// File: rtl/mixcolumns_engine.sv
// Handshaked AES MixColumns / InvMixColumns / bypass stage transforming
// COLS_PER_CYCLE columns of an internal state register per clock.
module mixcolumns_engine
    import mixcolumns_engine_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
)
(
    input  logic               clk,
    input  logic               rst,
    mixcolumns_engine_if.slave bus
);

    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

    mc_state_t             state_r;
    mc_state_t             state_nx;
    logic [TEXT_WIDTH-1:0] data_r;
    logic [TEXT_WIDTH-1:0] data_nx;
    logic [1:0]            mode_r;
    logic [1:0]            mode_nx;
    logic [1:0]            col_cnt_r;
    logic [1:0]            cnt_nx;
    logic                  out_valid_r;
    logic                  busy_r;
    logic                  in_ready_s;
    logic                  load_s;
    logic [COL_WIDTH-1:0]  col_in_s  [COLS_PER_CYCLE];
    logic [COL_WIDTH-1:0]  col_out_s [COLS_PER_CYCLE];

    // Instance i always works on column col_cnt+i, so the instances never overlap.
    for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
        assign col_in_s[gi] = get_col(data_r, col_cnt_r + 2'(gi));
        mix_single_column u_col (
            .col_i (col_in_s[gi]),
            .inv_i (mode_r == MC_INV),
            .col_o (col_out_s[gi])
        );
    end

    // Acceptance: idle, or a result leaving DONE this very edge (zero-bubble).
    always_comb begin
        in_ready_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && bus.out_ready);
        load_s     = bus.in_valid && in_ready_s;
    end

    // Next-state and datapath update.
    always_comb begin
        state_nx = state_r;
        data_nx  = data_r;
        mode_nx  = mode_r;
        cnt_nx   = col_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (load_s) begin
                    data_nx  = bus.in_data;
                    mode_nx  = bus.in_mode;
                    cnt_nx   = 2'd0;
                    state_nx = mc_is_bypass(bus.in_mode) ? ST_DONE : ST_BUSY;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_BUSY: begin
                for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                    data_nx = put_col(data_nx, col_cnt_r + 2'(i), col_out_s[i]);
                end
                cnt_nx = col_cnt_r + CNT_STEP;
                if (col_cnt_r == CNT_LAST) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (load_s) begin
                    data_nx  = bus.in_data;
                    mode_nx  = bus.in_mode;
                    cnt_nx   = 2'd0;
                    state_nx = mc_is_bypass(bus.in_mode) ? ST_DONE : ST_BUSY;
                end else if (bus.out_ready) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_DONE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State register; output flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            data_r      <= {TEXT_WIDTH{1'b0}};
            mode_r      <= MC_FWD;
            col_cnt_r   <= 2'd0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx;
            data_r      <= data_nx;
            mode_r      <= mode_nx;
            col_cnt_r   <= cnt_nx;
            out_valid_r <= (state_nx == ST_DONE);
            busy_r      <= (state_nx == ST_BUSY);
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = data_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mixcolumns_engine.sv
// Self-checking bench: three engines (1, 2 and 4 columns per cycle) against a
// log/antilog-table GF(2^8) matrix model.
module tb_mixcolumns_engine;
    import mixcolumns_engine_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]   rst_a;
    logic [2:0]   in_valid_a;
    logic [2:0]   out_ready_a;
    logic [1:0]   in_mode_a [3];
    logic [127:0] in_data_a [3];
    logic [2:0]   in_ready_w;
    logic [2:0]   out_valid_w;
    logic [2:0]   busy_w;
    logic [127:0] out_data_w [3];

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_t [256];
    logic [7:0] log_t [256];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CPC = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        mixcolumns_engine_if bus ();
        assign bus.in_valid    = in_valid_a[g];
        assign bus.in_mode     = in_mode_a[g];
        assign bus.in_data     = in_data_a[g];
        assign bus.out_ready   = out_ready_a[g];
        assign in_ready_w[g]   = bus.in_ready;
        assign out_valid_w[g]  = bus.out_valid;
        assign busy_w[g]       = bus.busy;
        assign out_data_w[g]   = bus.out_data;
        mixcolumns_engine #(.COLS_PER_CYCLE(CPC)) u_dut (
            .clk (clk),
            .rst (rst_a[g]),
            .bus (bus)
        );
    end

    function automatic int cpc_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    function automatic int lat_of(input int k, input logic [1:0] mode);
        return (mode[1]) ? 0 : 4 / cpc_of(k);
    endfunction

    // Powers of the generator 0x03, reduced modulo x^8+x^4+x^3+x+1.
    task automatic build_tables();
        logic [8:0] x;
        x = 9'd1;
        log_t[0] = 8'h00;
        for (int i = 0; i < 255; i++) begin
            exp_t[i]      = x[7:0];
            log_t[x[7:0]] = 8'(i);
            x = {x[7:0], 1'b0} ^ x;
            if (x[8]) x = x ^ 9'h11b;
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        int s;
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        s = (int'(log_t[a]) + int'(log_t[b])) % 255;
        return exp_t[s];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic [1:0] mode);
        logic [7:0]   base [4];
        logic [127:0] r;
        logic [7:0]   acc;
        if (mode == MC_FWD) base = '{8'h02, 8'h03, 8'h01, 8'h01};
        else if (mode == MC_INV) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else return s;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gf_mul(base[(j - row + 4) % 4], s[127 - 8*(4*c + j) -: 8]);
                end
                r[127 - 8*(4*c + row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one state until accepted, then scramble the idle inputs.
    task automatic send(input int k, input logic [1:0] mode, input logic [127:0] data);
        bit rdy;
        bit ok;
        ok = 1'b0;
        in_valid_a[k] = 1'b1;
        in_mode_a[k]  = mode;
        in_data_a[k]  = data;
        for (int t = 0; t < 40 && !ok; t++) begin
            #1;
            rdy = in_ready_w[k];
            tick();
            ok = rdy;
        end
        in_valid_a[k] = 1'b0;
        in_mode_a[k]  = 2'($urandom_range(0, 3));
        in_data_a[k]  = rnd128();
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL send_timeout[%0d]: accepted=%0b want 1", k, ok);
        end
    endtask

    // Wait for a result (out_ready high), count edges since accept, consume it.
    task automatic recv(input int k, output logic [127:0] data, output int lat);
        lat = 0;
        while (!out_valid_w[k] && lat < 40) begin
            tick();
            lat++;
        end
        data = out_data_w[k];
        n_cmp++;
        if (out_valid_w[k] !== 1'b1) begin
            n_err++;
            $display("FAIL recv_timeout[%0d]: out_valid=%0b want 1", k, out_valid_w[k]);
        end
        tick();
    endtask

    task automatic test_reset();
        rst_a = 3'b111;
        in_valid_a = 3'b000;
        out_ready_a = 3'b111;
        for (int k = 0; k < 3; k++) begin
            in_mode_a[k] = MC_FWD;
            in_data_a[k] = '0;
        end
        repeat (3) tick();
        rst_a = 3'b000;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (in_ready_w[k] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready[%0d]: got %0b want 1", k, in_ready_w[k]); end
            n_cmp++;
            if (out_valid_w[k] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid[%0d]: got %0b want 0", k, out_valid_w[k]); end
            n_cmp++;
            if (busy_w[k] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d]: got %0b want 0", k, busy_w[k]); end
            n_cmp++;
            if (out_data_w[k] !== 128'h0) begin n_err++; $display("FAIL reset_out_data[%0d]: got %h want 0", k, out_data_w[k]); end
        end
    endtask

    task automatic test_known_vectors();
        logic [127:0] got;
        int lat;
        for (int k = 0; k < 3; k++) begin
            send(k, MC_FWD, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
            recv(k, got, lat);
            n_cmp++;
            if (got !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6) begin n_err++; $display("FAIL fwd_vector[%0d]: got %h", k, got); end
            n_cmp++;
            if (lat != 4 / cpc_of(k)) begin n_err++; $display("FAIL fwd_latency[%0d]: got %0d want %0d", k, lat, 4 / cpc_of(k)); end
            send(k, MC_INV, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8);
            recv(k, got, lat);
            n_cmp++;
            if (got !== 128'hdb135345_f20a225c_d4d4d4d5_2d26314c) begin n_err++; $display("FAIL inv_vector[%0d]: got %h", k, got); end
            n_cmp++;
            if (lat != 4 / cpc_of(k)) begin n_err++; $display("FAIL inv_latency[%0d]: got %0d want %0d", k, lat, 4 / cpc_of(k)); end
        end
    endtask

    task automatic test_bypass_stream();
        logic [127:0] d [8];
        for (int k = 0; k < 3; k++) begin
            d[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
            for (int i = 1; i < 8; i++) d[i] = rnd128();
            in_valid_a[k] = 1'b1;
            in_mode_a[k]  = MC_BYP;
            in_data_a[k]  = d[0];
            tick();
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (out_valid_w[k] !== 1'b1 || out_data_w[k] !== d[i]) begin
                    n_err++;
                    $display("FAIL bypass_stream[%0d][%0d]: valid=%0b data=%h want %h", k, i, out_valid_w[k], out_data_w[k], d[i]);
                end
                if (i < 7) begin
                    in_data_a[k] = d[i + 1];
                    in_mode_a[k] = (i % 2 == 0) ? 2'b11 : MC_BYP;
                end else begin
                    in_valid_a[k] = 1'b0;
                end
                tick();
            end
            n_cmp++;
            if (out_valid_w[k] !== 1'b0) begin n_err++; $display("FAIL bypass_drain[%0d]: out_valid=%0b want 0", k, out_valid_w[k]); end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] x, y, expx, got;
        int lat;
        x = rnd128();
        y = rnd128();
        expx = ref_mix(x, MC_FWD);
        out_ready_a[0] = 1'b0;
        send(0, MC_FWD, x);
        for (int t = 0; t < 20 && !out_valid_w[0]; t++) tick();
        in_valid_a[0] = 1'b1;
        in_mode_a[0]  = MC_INV;
        in_data_a[0]  = y;
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (out_valid_w[0] !== 1'b1 || out_data_w[0] !== expx || in_ready_w[0] !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure_hold[%0d]: valid=%0b ready=%0b data=%h want %h", c, out_valid_w[0], in_ready_w[0], out_data_w[0], expx);
            end
            tick();
        end
        out_ready_a[0] = 1'b1;
        #1;
        n_cmp++;
        if (in_ready_w[0] !== 1'b1) begin n_err++; $display("FAIL backpressure_release_ready: got %0b want 1", in_ready_w[0]); end
        tick();
        in_valid_a[0] = 1'b0;
        n_cmp++;
        if (out_valid_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure_single_handshake: valid=%0b busy=%0b want 0/1", out_valid_w[0], busy_w[0]);
        end
        recv(0, got, lat);
        n_cmp++;
        if (got !== ref_mix(y, MC_INV) || lat != 4) begin
            n_err++;
            $display("FAIL backpressure_next: got %h lat %0d want %h lat 4", got, lat, ref_mix(y, MC_INV));
        end
        tick();
        n_cmp++;
        if (out_valid_w[0] !== 1'b0) begin n_err++; $display("FAIL backpressure_extra_result: out_valid=%0b want 0", out_valid_w[0]); end
    endtask

    task automatic test_reset_busy();
        logic [127:0] got;
        int lat;
        bit seen;
        send(0, MC_FWD, rnd128());
        tick();
        tick();
        n_cmp++;
        if (busy_w[0] !== 1'b1) begin n_err++; $display("FAIL rst_busy_pre: busy=%0b want 1", busy_w[0]); end
        rst_a[0] = 1'b1;
        tick();
        rst_a[0] = 1'b0;
        n_cmp++;
        if (out_valid_w[0] !== 1'b0 || in_ready_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || out_data_w[0] !== 128'h0) begin
            n_err++;
            $display("FAIL rst_busy_idle: valid=%0b ready=%0b busy=%0b data=%h", out_valid_w[0], in_ready_w[0], busy_w[0], out_data_w[0]);
        end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            seen = seen | out_valid_w[0];
            tick();
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL rst_busy_no_pulse: saw out_valid=%0b want 0", seen); end
        rst_a[0] = 1'b1;
        in_valid_a[0] = 1'b1;
        in_mode_a[0]  = MC_BYP;
        in_data_a[0]  = rnd128();
        tick();
        rst_a[0] = 1'b0;
        in_valid_a[0] = 1'b0;
        tick();
        n_cmp++;
        if (out_valid_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
            n_err++;
            $display("FAIL rst_wins_accept: valid=%0b busy=%0b want 0/0", out_valid_w[0], busy_w[0]);
        end
        send(0, MC_FWD, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
        recv(0, got, lat);
        n_cmp++;
        if (got !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6 || lat != 4) begin
            n_err++;
            $display("FAIL rst_busy_recover: got %h lat %0d", got, lat);
        end
    endtask

    task automatic test_random();
        logic [127:0] x, got, back;
        logic [1:0]   mode;
        int lat;
        for (int k = 0; k < 3; k++) begin
            for (int it = 0; it < 1000; it++) begin
                mode = 2'($urandom_range(0, 3));
                x = rnd128();
                send(k, mode, x);
                recv(k, got, lat);
                n_cmp++;
                if (got !== ref_mix(x, mode)) begin
                    n_err++;
                    $display("FAIL random_data[%0d][%0d]: mode %0d in %h got %h want %h", k, it, mode, x, got, ref_mix(x, mode));
                end
                n_cmp++;
                if (lat != lat_of(k, mode)) begin
                    n_err++;
                    $display("FAIL random_latency[%0d][%0d]: got %0d want %0d", k, it, lat, lat_of(k, mode));
                end
                if (mode == MC_FWD) begin
                    send(k, MC_INV, got);
                    recv(k, back, lat);
                    n_cmp++;
                    if (back !== x) begin
                        n_err++;
                        $display("FAIL random_roundtrip[%0d][%0d]: got %h want %h", k, it, back, x);
                    end
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_tables();
        test_reset();
        test_known_vectors();
        test_bypass_stream();
        test_backpressure();
        test_reset_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
